// File: rtl/ls595_deser.sv
// Serial-in/parallel-out deserializer with holding register (74LS595 flavour).
// Collects WIDTH bits per word, hands completed words over with a valid/ack handshake.
module ls595_deser #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CNT_W    = $clog2(WIDTH)
) (
   input  logic             clk1,
   input  logic             n_clr1,
   input  logic             ce,
   input  logic             ser,
   input  logic             sync,
   input  logic             n_srclr,
   input  logic             out_ack,
   input  logic             ovr_clr,
   input  logic             n_oe,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             qh_ser,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] sr_p0;
   logic [CNT_W-1:0] cnt_p0;
   logic [WIDTH-1:0] hold_p1;
   logic             vld_p1;
   logic             ovr_p1;
   logic [WIDTH-1:0] sr_next;
   logic             complete;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
      if (MSB_FIRST) return {cur[WIDTH-2:0], b};
      else           return {b, cur[WIDTH-1:1]};
   endfunction

   assign sr_next  = shift_in(sr_p0, ser);
   // sync on what would be the completing edge starts a new word instead
   assign complete = n_srclr && ce && !sync && (cnt_p0 == LAST);

   // stage 0: shift register and bit counter
   always_ff @(posedge clk1 or negedge n_clr1) begin
      if (!n_clr1) begin
         sr_p0  <= '0;
         cnt_p0 <= '0;
      end else if (!n_srclr) begin
         sr_p0  <= '0;
         cnt_p0 <= '0;
      end else if (ce) begin
         sr_p0 <= sr_next;
         if (sync)          cnt_p0 <= CNT_W'(1);
         else if (complete) cnt_p0 <= '0;
         else               cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
   end

   // stage 1: holding register, handshake and overrun
   always_ff @(posedge clk1 or negedge n_clr1) begin
      if (!n_clr1) begin
         hold_p1 <= '0;
         vld_p1  <= 1'b0;
         ovr_p1  <= 1'b0;
      end else begin
         if (complete) hold_p1 <= sr_next;

         if (complete)     vld_p1 <= 1'b1;
         else if (out_ack) vld_p1 <= 1'b0;

         if (complete && vld_p1 && !out_ack) ovr_p1 <= 1'b1;
         else if (ovr_clr)                   ovr_p1 <= 1'b0;
      end
   end

   assign q       = n_oe ? '0 : hold_p1;
   assign q_valid = vld_p1;
   assign overrun = ovr_p1;
   assign bit_cnt = cnt_p0;
   assign qh_ser  = MSB_FIRST ? sr_p0[WIDTH-1] : sr_p0[0];

endmodule

// File: tb/tb_ls595_deser.sv
// Bench for ls595_deser: MSB-first and LSB-first instances on shared inputs, checked
// against a bit-history model of received words, plus directed frame scenarios.
module tb_ls595_deser;

   localparam int W = 8;

   logic         clk1 = 1'b0;
   logic         n_clr1, ce, ser, sync, n_srclr, out_ack, ovr_clr, n_oe;
   logic [W-1:0] q_m, q_l;
   logic         qv_m, qv_l, qh_m, qh_l, ovr_m, ovr_l;
   logic [2:0]   cnt_m, cnt_l;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk1 = ~clk1;

   ls595_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk1(clk1), .n_clr1(n_clr1), .ce(ce), .ser(ser), .sync(sync), .n_srclr(n_srclr),
      .out_ack(out_ack), .ovr_clr(ovr_clr), .n_oe(n_oe),
      .q(q_m), .q_valid(qv_m), .qh_ser(qh_m), .bit_cnt(cnt_m), .overrun(ovr_m));

   ls595_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk1(clk1), .n_clr1(n_clr1), .ce(ce), .ser(ser), .sync(sync), .n_srclr(n_srclr),
      .out_ack(out_ack), .ovr_clr(ovr_clr), .n_oe(n_oe),
      .q(q_l), .q_valid(qv_l), .qh_ser(qh_l), .bit_cnt(cnt_l), .overrun(ovr_l));

   // reference: the last W received bits (oldest first), words captured from that window
   bit       win[$];
   int       m_cnt;
   bit [W-1:0] m_hold_m, m_hold_l;
   bit       m_vld, m_ovr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit [W-1:0] word_msb();
      bit [W-1:0] w;
      for (int i = 0; i < W; i++) w[W-1-i] = win[i];
      return w;
   endfunction

   function automatic bit [W-1:0] word_lsb();
      bit [W-1:0] w;
      for (int i = 0; i < W; i++) w[i] = win[i];
      return w;
   endfunction

   task automatic model_reset();
      win.delete();
      for (int i = 0; i < W; i++) win.push_back(1'b0);
      m_cnt = 0; m_hold_m = '0; m_hold_l = '0; m_vld = 0; m_ovr = 0;
   endtask

   task automatic model_step();
      bit done = 0;
      if (!n_srclr) begin
         for (int i = 0; i < W; i++) win[i] = 1'b0;
         m_cnt = 0;
      end else if (ce) begin
         void'(win.pop_front());
         win.push_back(ser);
         if (sync) m_cnt = 1;
         else if (m_cnt == W - 1) begin m_cnt = 0; done = 1; end
         else m_cnt = m_cnt + 1;
      end
      if (done) begin
         m_hold_m = word_msb();
         m_hold_l = word_lsb();
         if (m_vld && !out_ack) m_ovr = 1;
         else if (ovr_clr)      m_ovr = 0;
         m_vld = 1;
      end else begin
         if (out_ack) m_vld = 0;
         if (ovr_clr) m_ovr = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".q_m"},   q_m,   n_oe ? 0 : m_hold_m);
      chk({tag, ".q_l"},   q_l,   n_oe ? 0 : m_hold_l);
      chk({tag, ".qv_m"},  qv_m,  m_vld);
      chk({tag, ".qv_l"},  qv_l,  m_vld);
      chk({tag, ".cnt_m"}, cnt_m, m_cnt);
      chk({tag, ".cnt_l"}, cnt_l, m_cnt);
      chk({tag, ".ovr_m"}, ovr_m, m_ovr);
      chk({tag, ".ovr_l"}, ovr_l, m_ovr);
      chk({tag, ".qh_m"},  qh_m,  win[0]);
      chk({tag, ".qh_l"},  qh_l,  win[0]);
   endtask

   task automatic cyc(input string tag, input logic c, input logic s, input logic sy,
                      input logic clr_n, input logic ack, input logic oclr, input logic oe_n);
      ce = c; ser = s; sync = sy; n_srclr = clr_n; out_ack = ack; ovr_clr = oclr; n_oe = oe_n;
      @(posedge clk1);
      model_step();
      #1;
      check_all(tag);
   endtask

   // bits go out q[W-1] first, as an ls166 would shift them
   task automatic send_word(input string tag, input logic [W-1:0] w, input logic sy,
                            input logic ack_last);
      for (int i = W - 1; i >= 0; i--)
         cyc(tag, 1'b1, w[i], sy && (i == W - 1), 1'b1, ack_last && (i == 0), 1'b0, 1'b0);
   endtask

   task automatic async_reset(input string tag);
      n_clr1 = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      chk({tag, ".q0"}, {q_m, q_l, 6'b0, qv_m, ovr_m}, 0);
      #1;
      n_clr1 = 1'b1;
   endtask

   initial begin
      n_clr1 = 1'b0; ce = 0; ser = 0; sync = 0; n_srclr = 1; out_ack = 0; ovr_clr = 0; n_oe = 0;
      model_reset();
      #2;
      check_all("reset");
      n_clr1 = 1'b1;

      // T1
      send_word("t1", 8'hA5, 1'b1, 1'b0);
      chk("t1.word", q_m, 8'hA5);
      chk("t1.valid", qv_m, 1'b1);
      cyc("t1.ack", 0, 0, 0, 1, 1, 0, 0);
      chk("t1.acked", qv_m, 1'b0);

      // T2: partial word discarded by sync
      for (int i = 0; i < 3; i++) cyc("t2.part", 1, 1'b1, i == 0, 1, 0, 0, 0);
      send_word("t2", 8'h3C, 1'b1, 1'b0);
      chk("t2.word", q_m, 8'h3C);
      cyc("t2.ack", 0, 0, 0, 1, 1, 0, 0);

      // T3: overrun
      send_word("t3a", 8'h11, 1'b1, 1'b0);
      send_word("t3b", 8'h22, 1'b0, 1'b0);
      chk("t3.word", q_m, 8'h22);
      chk("t3.ovr", ovr_m, 1'b1);
      cyc("t3.oclr", 0, 0, 0, 1, 0, 1, 0);
      chk("t3.ovr_clr", ovr_m, 1'b0);
      cyc("t3.ack", 0, 0, 0, 1, 1, 0, 0);
      chk("t3.acked", qv_m, 1'b0);

      // T4: ack coincides with completion
      send_word("t4a", 8'h55, 1'b1, 1'b0);
      send_word("t4b", 8'h77, 1'b0, 1'b1);
      chk("t4.word", q_m, 8'h77);
      chk("t4.valid", qv_m, 1'b1);
      chk("t4.ovr", ovr_m, 1'b0);
      cyc("t4.ack", 0, 0, 0, 1, 1, 0, 0);

      // T5: sync shift-clear keeps the holding register
      for (int i = 0; i < 4; i++) cyc("t5.part", 1, 1'b1, 0, 1, 0, 0, 0);
      cyc("t5.srclr", 1, 1, 1, 0, 0, 0, 0);
      chk("t5.cnt", cnt_m, 0);
      chk("t5.hold", q_m, 8'h77);
      send_word("t5", 8'hF0, 1'b0, 1'b0);
      chk("t5.word", q_m, 8'hF0);

      // T6: output enable, LSB-first landing, async clear mid-word
      cyc("t6.oe", 0, 0, 0, 1, 0, 0, 1);
      chk("t6.oe_q", q_m, 0);
      chk("t6.oe_v", qv_m, 1'b1);
      cyc("t6.ack", 0, 0, 0, 1, 1, 0, 0);
      send_word("t6.lsb", 8'h80, 1'b1, 1'b0);
      chk("t6.lsb_word", q_l, 8'h01);
      chk("t6.msb_word", q_m, 8'h80);
      for (int i = 0; i < 3; i++) cyc("t6.part", 1, 1'b1, 0, 1, 0, 0, 0);
      async_reset("t6.rst");
      send_word("t6.post", 8'hC3, 1'b0, 1'b0);
      chk("t6.post_word", q_m, 8'hC3);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) async_reset("rnd.rst");
         cyc("rnd",
             $urandom_range(0, 3) != 0,
             1'($urandom),
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 31) != 0,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 7) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
